clock_set_controller: RTL and testbench

- Front-panel controller for the 24-hour digital clock datapath; converts three raw active-low push-buttons (mode, up, down) into the four active-low add/subtract minute/hour step requests the clock consumes.
- Implements the set-mode state machine, debounce, hold-to-auto-repeat, idle timeout back to run mode, and blink enables for the field being edited.
- Sits between the board keys and the clock core, on the same 50 MHz clock.

---
 rtl/clock_set_controller_pkg.sv | 24 ++
 rtl/clock_set_controller_if.sv | 28 ++
 rtl/clock_set_controller_button_conditioner.sv | 53 +++++
 rtl/clock_set_controller.sv | 191 +++++++++++++++++++
 tb/tb_clock_set_controller.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/clock_set_controller_pkg.sv
// Shared definitions for the front-panel clock set controller: mode
// encoding, 50 MHz timing defaults and the idle level of the step outputs.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_HOLD_DELAY      = 25_000_000;
    localparam int DEFAULT_REPEAT_PERIOD   = 10_000_000;
    localparam int DEFAULT_IDLE_TIMEOUT    = 500_000_000;
    localparam int DEFAULT_BLINK_HALF      = 12_500_000;

    localparam logic STEP_IDLE = 1'b1;

    // Counter width able to hold 0 .. n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_set_controller_if.sv
// Key inputs, step requests and display controls exchanged between the
// board/clock core and the set controller.
interface clock_set_controller_if;

    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic       add_minute;
    logic       subtract_minute;
    logic       add_hour;
    logic       subtract_hour;
    logic [1:0] mode;
    logic       blank_hour;
    logic       blank_minute;

    modport master (
        output btn_mode, btn_up, btn_down,
        input  add_minute, subtract_minute, add_hour, subtract_hour,
        input  mode, blank_hour, blank_minute
    );

    modport slave (
        input  btn_mode, btn_up, btn_down,
        output add_minute, subtract_minute, add_hour, subtract_hour,
        output mode, blank_hour, blank_minute
    );

endinterface

// File: rtl/clock_set_controller_button_conditioner.sv
// Conditions one raw active-low key: synchronizes it into the clk domain,
// debounces it and flags a one-cycle press on each debounced 1->0 edge.
module button_conditioner
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] count;

    // Two-flop synchronizer; idles at the released level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    // Accept a new level only after a full run of identical samples; a press pulses with the falling level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            level <= 1'b1;
            count <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_b == level) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                level <= sync_b;
                count <= '0;
                press <= ~sync_b;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_set_controller.sv
// Front-panel controller: turns mode/up/down keys into single active-low
// hour/minute step requests, with auto-repeat, idle timeout and blinking.
module clock_set_controller
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_DELAY      = DEFAULT_HOLD_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
    parameter int IDLE_TIMEOUT    = DEFAULT_IDLE_TIMEOUT,
    parameter int BLINK_HALF      = DEFAULT_BLINK_HALF
) (
    input  logic clk,
    input  logic rst,
    clock_set_controller_if.slave bus
);

    localparam int HOLD_SPAN = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int IW = cnt_width(IDLE_TIMEOUT);
    localparam int HW = cnt_width(HOLD_SPAN);
    localparam int BW = cnt_width(BLINK_HALF);

    localparam logic [IW-1:0] IDLE_LAST   = IW'(IDLE_TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_DELAY - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_PERIOD - 1);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_HALF - 1);

    localparam int STEP_SUB_MIN  = 0;
    localparam int STEP_ADD_MIN  = 1;
    localparam int STEP_SUB_HOUR = 2;
    localparam int STEP_ADD_HOUR = 3;

    logic mode_level_unused;
    logic mode_press;
    logic up_level;
    logic up_press;
    logic down_level;
    logic down_press;

    mode_t         state;
    mode_t         state_next;
    logic [IW-1:0] idle_cnt;
    logic [IW-1:0] idle_next;
    logic          rep_active;
    logic          rep_active_next;
    logic          rep_is_up;
    logic          rep_is_up_next;
    logic          rep_repeating;
    logic          rep_repeating_next;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_next;
    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_next;
    logic          phase;
    logic          phase_next;
    logic [3:0]    step_req;
    logic [3:0]    step_n;

    logic in_set;
    logic any_press;
    logic both_held;
    logic mode_change;
    logic step_fire;
    logic step_up;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.btn_mode),
        .level   (mode_level_unused),
        .press   (mode_press)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.btn_up),
        .level   (up_level),
        .press   (up_press)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.btn_down),
        .level   (down_level),
        .press   (down_press)
    );

    // Register mode, repeat, idle and blink state plus the registered step outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= MODE_RUN;
            idle_cnt      <= '0;
            rep_active    <= 1'b0;
            rep_is_up     <= 1'b0;
            rep_repeating <= 1'b0;
            hold_cnt      <= '0;
            blink_cnt     <= '0;
            phase         <= 1'b0;
            step_n        <= {4{STEP_IDLE}};
        end else begin
            state         <= state_next;
            idle_cnt      <= idle_next;
            rep_active    <= rep_active_next;
            rep_is_up     <= rep_is_up_next;
            rep_repeating <= rep_repeating_next;
            hold_cnt      <= hold_next;
            blink_cnt     <= blink_next;
            phase         <= phase_next;
            step_n        <= ~step_req;
        end
    end

    // Next mode, idle count, press/auto-repeat step decision and blink phase.
    always_comb begin
        in_set             = (state != MODE_RUN);
        any_press          = mode_press | up_press | down_press;
        both_held          = ~up_level & ~down_level;
        state_next         = state;
        idle_next          = '0;
        rep_active_next    = 1'b0;
        rep_is_up_next     = rep_is_up;
        rep_repeating_next = 1'b0;
        hold_next          = '0;
        step_fire          = 1'b0;
        step_up            = 1'b0;
        step_req           = '0;
        blink_next         = '0;
        phase_next         = 1'b0;

        if (mode_press) begin
            case (state)
                MODE_RUN:      state_next = MODE_SET_HOUR;
                MODE_SET_HOUR: state_next = MODE_SET_MIN;
                default:       state_next = MODE_RUN;
            endcase
        end else if (in_set && !any_press && idle_cnt == IDLE_LAST) begin
            state_next = MODE_RUN;
        end
        mode_change = (state_next != state);

        if (in_set && !mode_change && !any_press) begin
            idle_next = idle_cnt + 1'b1;
        end

        if (in_set && !mode_change && !both_held) begin
            if (up_press || down_press) begin
                step_fire       = 1'b1;
                step_up         = up_press;
                rep_active_next = 1'b1;
                rep_is_up_next  = up_press;
            end else if (rep_active && (rep_is_up ? ~up_level : ~down_level)) begin
                rep_active_next    = 1'b1;
                rep_repeating_next = rep_repeating;
                if (hold_cnt == (rep_repeating ? REPEAT_LAST : HOLD_LAST)) begin
                    step_fire          = 1'b1;
                    step_up            = rep_is_up;
                    rep_repeating_next = 1'b1;
                end else begin
                    hold_next = hold_cnt + 1'b1;
                end
            end
        end

        if (step_fire) begin
            if (state == MODE_SET_HOUR) begin
                step_req[step_up ? STEP_ADD_HOUR : STEP_SUB_HOUR] = 1'b1;
            end else begin
                step_req[step_up ? STEP_ADD_MIN : STEP_SUB_MIN] = 1'b1;
            end
        end

        if (in_set && !mode_change && !step_fire) begin
            if (blink_cnt == BLINK_LAST) begin
                phase_next = ~phase;
            end else begin
                blink_next = blink_cnt + 1'b1;
                phase_next = phase;
            end
        end
    end

    assign bus.mode            = state;
    assign bus.add_hour        = step_n[STEP_ADD_HOUR];
    assign bus.subtract_hour   = step_n[STEP_SUB_HOUR];
    assign bus.add_minute      = step_n[STEP_ADD_MIN];
    assign bus.subtract_minute = step_n[STEP_SUB_MIN];
    assign bus.blank_hour      = phase & (state == MODE_SET_HOUR);
    assign bus.blank_minute    = phase & (state == MODE_SET_MIN);

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with short timing parameters.
// Cycle labels count clock edges after the most recent clearCounts call;
// keys driven at label N are first captured on edge N+1.
module tb_clock_set_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;

    clock_set_controller_if bus ();

    clock_set_controller #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_DELAY      (20),
        .REPEAT_PERIOD   (8),
        .IDLE_TIMEOUT    (100),
        .BLINK_HALF      (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;
    int rel;
    int am_cnt;
    int sh_cnt;
    int multi_total = 0;
    int sm_times[$];
    int ah_times[$];
    logic [1:0] mode_log [0:255];
    logic       bh_log   [0:255];
    int exp_sm[6] = '{7, 27, 35, 43, 51, 59};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic m, input logic u, input logic d);
        bus.btn_mode = m;
        bus.btn_up   = u;
        bus.btn_down = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int timeAt(input int q[$], input int idx);
        return (q.size() > idx) ? q[idx] : -1;
    endfunction

    function automatic int stepsTotal();
        return am_cnt + sh_cnt + sm_times.size() + ah_times.size();
    endfunction

    task automatic clearCounts();
        rel    = 0;
        am_cnt = 0;
        sh_cnt = 0;
        sm_times.delete();
        ah_times.delete();
    endtask

    // Advance n cycles, logging step pulses, mode and blank_hour per label.
    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            int lows;
            tick();
            rel++;
            lows = int'(!bus.add_minute) + int'(!bus.subtract_minute)
                 + int'(!bus.add_hour) + int'(!bus.subtract_hour);
            if (lows > 1) multi_total++;
            if (bus.add_minute === 1'b0) am_cnt++;
            if (bus.subtract_hour === 1'b0) sh_cnt++;
            if (bus.subtract_minute === 1'b0) sm_times.push_back(rel);
            if (bus.add_hour === 1'b0) ah_times.push_back(rel);
            if (rel < 256) begin
                mode_log[rel] = bus.mode;
                bh_log[rel]   = bus.blank_hour;
            end
        end
    endtask

    // Tap the mode key while leaving up/down at their current levels.
    task automatic pressMode();
        applyStimulus(1'b0, bus.btn_up, bus.btn_down);
        runCycles(8);
        applyStimulus(1'b1, bus.btn_up, bus.btn_down);
        runCycles(8);
    endtask

    initial begin
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        rst = 1'b0;
        clearCounts();

        // Reset with random keys, then released keys must leave everything idle.
        repeat (3) tick();
        checkOutput("reset_mode", 32'(bus.mode), 32'd0);
        checkOutput("reset_steps", 32'({bus.add_hour, bus.subtract_hour, bus.add_minute, bus.subtract_minute}), 32'hF);
        checkOutput("reset_blank", 32'({bus.blank_hour, bus.blank_minute}), 32'd0);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1);
        clearCounts();
        runCycles(50);
        checkOutput("quiet_mode", 32'(bus.mode), 32'd0);
        checkOutput("quiet_steps", stepsTotal(), 32'd0);

        // Enter SET_HOUR; one up press gives one add_hour pulse, a short bounce gives none.
        clearCounts();
        pressMode();
        checkOutput("enter_set_hour", 32'(bus.mode), 32'd1);
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b1);
        runCycles(10);
        applyStimulus(1'b1, 1'b1, 1'b1);
        runCycles(10);
        checkOutput("up_add_hour_count", ah_times.size(), 32'd1);
        checkOutput("up_add_hour_time", timeAt(ah_times, 0), 32'd7);
        checkOutput("up_other_steps", am_cnt + sh_cnt + sm_times.size(), 32'd0);
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b1);
        runCycles(2);
        applyStimulus(1'b1, 1'b1, 1'b1);
        runCycles(12);
        checkOutput("bounce_steps", stepsTotal(), 32'd0);

        // SET_MIN: hold down, expect initial step then hold delay and repeat period.
        clearCounts();
        pressMode();
        checkOutput("enter_set_min", 32'(bus.mode), 32'd2);
        clearCounts();
        applyStimulus(1'b1, 1'b1, 1'b0);
        runCycles(60);
        applyStimulus(1'b1, 1'b1, 1'b1);
        runCycles(30);
        checkOutput("repeat_count", sm_times.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("repeat_time_%0d", i), timeAt(sm_times, i), exp_sm[i]);
        end
        checkOutput("repeat_other_steps", stepsTotal() - sm_times.size(), 32'd0);

        // Up and down together in SET_HOUR, then up in RUN: no steps at all.
        clearCounts();
        pressMode();
        pressMode();
        checkOutput("back_to_set_hour", 32'(bus.mode), 32'd1);
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b0);
        runCycles(40);
        applyStimulus(1'b1, 1'b1, 1'b1);
        runCycles(12);
        checkOutput("both_keys_steps", stepsTotal(), 32'd0);
        pressMode();
        pressMode();
        checkOutput("back_to_run", 32'(bus.mode), 32'd0);
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b1);
        runCycles(10);
        applyStimulus(1'b1, 1'b1, 1'b1);
        runCycles(12);
        checkOutput("run_up_steps", stepsTotal(), 32'd0);

        // Blink period and idle timeout without presses.
        clearCounts();
        applyStimulus(1'b0, 1'b1, 1'b1);
        runCycles(8);
        applyStimulus(1'b1, 1'b1, 1'b1);
        runCycles(112);
        checkOutput("blink_mode_before", 32'(mode_log[6]), 32'd0);
        checkOutput("blink_mode_entered", 32'(mode_log[7]), 32'd1);
        checkOutput("blink_off_12", 32'(bh_log[12]), 32'd0);
        checkOutput("blink_on_13", 32'(bh_log[13]), 32'd1);
        checkOutput("blink_on_18", 32'(bh_log[18]), 32'd1);
        checkOutput("blink_off_19", 32'(bh_log[19]), 32'd0);
        checkOutput("timeout_last_set", 32'(mode_log[106]), 32'd1);
        checkOutput("timeout_run", 32'(mode_log[107]), 32'd0);
        checkOutput("timeout_blank", 32'(bh_log[107]), 32'd0);

        // A press landing on the last idle cycle restarts the timeout.
        clearCounts();
        applyStimulus(1'b0, 1'b1, 1'b1);
        runCycles(8);
        applyStimulus(1'b1, 1'b1, 1'b1);
        runCycles(91);
        applyStimulus(1'b1, 1'b0, 1'b1);
        runCycles(11);
        applyStimulus(1'b1, 1'b1, 1'b1);
        runCycles(110);
        checkOutput("late_press_step_time", timeAt(ah_times, 0), 32'd106);
        checkOutput("late_press_step_count", stepsTotal(), 32'd1);
        checkOutput("late_press_kept_107", 32'(mode_log[107]), 32'd1);
        checkOutput("late_press_kept_205", 32'(mode_log[205]), 32'd1);
        checkOutput("late_press_timeout_206", 32'(mode_log[206]), 32'd0);

        // Reset in the middle of auto-repeat; a still-held key must not step afterwards.
        clearCounts();
        pressMode();
        pressMode();
        checkOutput("pre_reset_set_min", 32'(bus.mode), 32'd2);
        clearCounts();
        applyStimulus(1'b1, 1'b1, 1'b0);
        runCycles(40);
        checkOutput("pre_reset_repeats", sm_times.size(), 32'd3);
        rst = 1'b0;
        runCycles(1);
        checkOutput("midrep_reset_mode", 32'(bus.mode), 32'd0);
        checkOutput("midrep_reset_steps", 32'({bus.add_hour, bus.subtract_hour, bus.add_minute, bus.subtract_minute}), 32'hF);
        checkOutput("midrep_reset_blank", 32'({bus.blank_hour, bus.blank_minute}), 32'd0);
        rst = 1'b1;
        clearCounts();
        runCycles(60);
        checkOutput("post_reset_held_steps", stepsTotal(), 32'd0);
        checkOutput("post_reset_mode", 32'(bus.mode), 32'd0);
        pressMode();
        checkOutput("held_across_mode", 32'(bus.mode), 32'd1);
        runCycles(40);
        applyStimulus(1'b1, 1'b1, 1'b1);
        runCycles(10);
        checkOutput("held_across_mode_steps", stepsTotal(), 32'd0);

        checkOutput("single_step_low", multi_total, 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
